// File: rtl/add8_exh_characterizer.sv
// rtl/add8_exh_characterizer.sv - exhaustive error characterizer for 8-bit approximate adders
module add8_exh_characterizer #(
    parameter int LAT = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    output logic [7:0]  A_O,
    output logic [7:0]  B_O,
    input  logic [8:0]  O_I,
    output logic        BUSY,
    output logic        DONE,
    output logic [16:0] SAMPLES,
    output logic [16:0] ERR_CNT,
    output logic [24:0] SUM_AE,
    output logic [34:0] SUM_SE,
    output logic [8:0]  WCE,
    output logic [7:0]  WCE_A,
    output logic [7:0]  WCE_B
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_idx;
    logic        w_start;
    logic        w_issue;
    logic        w_al_v;
    logic [7:0]  w_al_a;
    logic [7:0]  w_al_b;
    logic [8:0]  w_exact;
    logic [8:0]  w_ae;
    logic [17:0] w_se;

    assign w_start = START && (r_state == S_IDLE || r_state == S_DONE);
    assign w_issue = (r_state == S_RUN);
    assign A_O     = w_issue ? r_idx[7:0]  : 8'd0;
    assign B_O     = w_issue ? r_idx[15:8] : 8'd0;
    assign BUSY    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign DONE    = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (START) w_next = S_RUN;
            S_DONE:  if (START) w_next = S_RUN;
            // without a pipeline the final result lands on the RUN exit edge
            S_RUN:   if (r_idx == 16'hFFFF) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (r_idx == 16'(LAT - 1)) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_idx wraps to 0 on leaving RUN and then counts the drain cycles
    always_ff @(posedge CLK) begin
        if (!RST_N || w_start) begin
            r_idx <= 16'd0;
        end else if (BUSY) begin
            r_idx <= r_idx + 16'd1;
        end
    end

    generate
        if (LAT == 0) begin : g_nodl
            assign w_al_v = w_issue;
            assign w_al_a = A_O;
            assign w_al_b = B_O;
        end else begin : g_dl
            logic [16:0] r_dl [LAT];
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    for (int k = 0; k < LAT; k++) r_dl[k] <= 17'd0;
                end else begin
                    r_dl[0] <= {w_issue, A_O, B_O};
                    for (int k = 1; k < LAT; k++) r_dl[k] <= r_dl[k-1];
                end
            end
            assign {w_al_v, w_al_a, w_al_b} = r_dl[LAT-1];
        end
    endgenerate

    assign w_exact = {1'b0, w_al_a} + {1'b0, w_al_b};
    assign w_ae    = (O_I >= w_exact) ? (O_I - w_exact) : (w_exact - O_I);
    assign w_se    = {9'd0, w_ae} * {9'd0, w_ae};

    always_ff @(posedge CLK) begin
        if (!RST_N || w_start) begin
            SAMPLES <= 17'd0;
            ERR_CNT <= 17'd0;
            SUM_AE  <= 25'd0;
            SUM_SE  <= 35'd0;
            WCE     <= 9'd0;
            WCE_A   <= 8'd0;
            WCE_B   <= 8'd0;
        end else if (w_al_v) begin
            SAMPLES <= SAMPLES + 17'd1;
            ERR_CNT <= ERR_CNT + {16'd0, (w_ae != 9'd0)};
            SUM_AE  <= SUM_AE + {16'd0, w_ae};
            SUM_SE  <= SUM_SE + {17'd0, w_se};
            if (w_ae > WCE) begin
                WCE   <= w_ae;
                WCE_A <= w_al_a;
                WCE_B <= w_al_b;
            end
        end
    end

endmodule

// File: tb/tb_add8_exh_characterizer.sv
// tb/tb_add8_exh_characterizer.sv - self-checking bench for add8_exh_characterizer
module tb_add8_exh_characterizer;

    localparam int ND = 5;
    localparam logic [1:0] M_EXACT = 2'd0, M_MASK = 2'd1, M_ZERO = 2'd2, M_PLUS1 = 2'd3;

    typedef struct {
        int     dut;
        int     lat;
        longint samples;
        longint err;
        longint sae;
        longint sse;
        longint wce;
        longint wa;
        longint wb;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        rst_n [ND];
    logic        start [ND];
    logic [1:0]  mode  [ND];
    logic [7:0]  a_o   [ND];
    logic [7:0]  b_o   [ND];
    logic [8:0]  o_i   [ND];
    logic        busy  [ND];
    logic        done  [ND];
    logic [16:0] samples [ND];
    logic [16:0] err_cnt [ND];
    logic [24:0] sum_ae  [ND];
    logic [34:0] sum_se  [ND];
    logic [8:0]  wce     [ND];
    logic [7:0]  wce_a   [ND];
    logic [7:0]  wce_b   [ND];

    int done_cyc  [ND] = '{default: -1};
    int busy_last [ND] = '{default: -1};
    int both_hi   [ND] = '{default: 0};

    int n_tests = 0;
    int n_fail  = 0;
    int t0;
    exp_t tbl [4];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            M_EXACT: return s;
            M_MASK:  return s & 9'h1FE;
            M_ZERO:  return 9'd0;
            default: return s + 9'd1;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [8:0] w_comb;
        logic [8:0] r_p1 = 9'd0;
        logic [8:0] r_p2 = 9'd0;
        assign w_comb = model(mode[g], a_o[g], b_o[g]);
        always @(posedge clk) begin
            r_p1 <= w_comb;
            r_p2 <= r_p1;
        end
        assign o_i[g] = (g == 3) ? r_p2 : w_comb;

        add8_exh_characterizer #(.LAT((g == 3) ? 2 : 0)) u_dut (
            .CLK(clk), .RST_N(rst_n[g]), .START(start[g]),
            .A_O(a_o[g]), .B_O(b_o[g]), .O_I(o_i[g]),
            .BUSY(busy[g]), .DONE(done[g]),
            .SAMPLES(samples[g]), .ERR_CNT(err_cnt[g]),
            .SUM_AE(sum_ae[g]), .SUM_SE(sum_se[g]),
            .WCE(wce[g]), .WCE_A(wce_a[g]), .WCE_B(wce_b[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (busy[k]) busy_last[k] <= cyc;
            if (done[k] && done_cyc[k] < 0) done_cyc[k] <= cyc;
            if (busy[k] && done[k]) both_hi[k] <= 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s busy d%0d", tag, d), busy[d], 0);
        chk($sformatf("%s done d%0d", tag, d), done[d], 0);
        chk($sformatf("%s a_o d%0d", tag, d), a_o[d], 0);
        chk($sformatf("%s b_o d%0d", tag, d), b_o[d], 0);
        chk($sformatf("%s samples d%0d", tag, d), samples[d], 0);
        chk($sformatf("%s err_cnt d%0d", tag, d), err_cnt[d], 0);
        chk($sformatf("%s sum_ae d%0d", tag, d), sum_ae[d], 0);
        chk($sformatf("%s sum_se d%0d", tag, d), sum_se[d], 0);
        chk($sformatf("%s wce d%0d", tag, d), wce[d], 0);
        chk($sformatf("%s wce_a d%0d", tag, d), wce_a[d], 0);
        chk($sformatf("%s wce_b d%0d", tag, d), wce_b[d], 0);
    endtask

    initial begin
        tbl[0] = '{dut: 0, lat: 0, samples: 65536, err: 0,     sae: 0,        sse: 0,           wce: 0,   wa: 0,   wb: 0};
        tbl[1] = '{dut: 1, lat: 0, samples: 65536, err: 32768, sae: 32768,    sse: 32768,       wce: 1,   wa: 1,   wb: 0};
        tbl[2] = '{dut: 2, lat: 0, samples: 65536, err: 65535, sae: 16711680, sse: 64'd4977295360, wce: 510, wa: 255, wb: 255};
        tbl[3] = '{dut: 3, lat: 2, samples: 65536, err: 65536, sae: 65536,    sse: 65536,       wce: 1,   wa: 0,   wb: 0};

        for (int k = 0; k < ND; k++) begin
            rst_n[k] = 1'b0;
            start[k] = 1'b0;
        end
        mode[0] = M_EXACT; mode[1] = M_MASK; mode[2] = M_ZERO; mode[3] = M_PLUS1; mode[4] = M_EXACT;

        repeat (3) @(negedge clk);
        for (int k = 0; k < ND; k++) rst_n[k] = 1'b1;
        for (int k = 0; k < ND; k++) chk_zero(k, "reset");

        for (int k = 0; k < ND; k++) start[k] = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back(tbl[k]);
        @(negedge clk);
        for (int k = 0; k < ND; k++) start[k] = 1'b0;
        t0 = cyc;
        chk("first busy d0", busy[0], 1);
        chk("first a_o d0", a_o[0], 0);

        while (cyc < t0 + 1000) @(negedge clk);
        chk("idx1000 a_o d0", a_o[0], 232);
        chk("idx1000 b_o d0", b_o[0], 3);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("restart ignored busy d0", busy[0], 1);
        chk("restart ignored a_o d0", a_o[0], 233);
        chk("restart ignored b_o d0", b_o[0], 3);

        while (cyc < t0 + 30000) @(negedge clk);
        chk("idx30000 a_o d4", a_o[4], 48);
        chk("idx30000 b_o d4", b_o[4], 117);
        rst_n[4] = 1'b0;
        @(negedge clk);
        rst_n[4] = 1'b1;
        chk_zero(4, "midrun reset");
        @(negedge clk);
        chk("idle after reset busy d4", busy[4], 0);
        chk("idle after reset a_o d4", a_o[4], 0);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (!done[e.dut] && cyc < t0 + 66000) @(negedge clk);
            #1;
            chk($sformatf("done cycle d%0d", e.dut), done_cyc[e.dut], t0 + 65536 + e.lat);
            chk($sformatf("last busy d%0d", e.dut), busy_last[e.dut], t0 + 65535 + e.lat);
            chk($sformatf("samples d%0d", e.dut), samples[e.dut], e.samples);
            chk($sformatf("err_cnt d%0d", e.dut), err_cnt[e.dut], e.err);
            chk($sformatf("sum_ae d%0d", e.dut), sum_ae[e.dut], e.sae);
            chk($sformatf("sum_se d%0d", e.dut), sum_se[e.dut], e.sse);
            chk($sformatf("wce d%0d", e.dut), wce[e.dut], e.wce);
            chk($sformatf("wce_a d%0d", e.dut), wce_a[e.dut], e.wa);
            chk($sformatf("wce_b d%0d", e.dut), wce_b[e.dut], e.wb);
            chk($sformatf("busy and done d%0d", e.dut), both_hi[e.dut], 0);
        end

        @(negedge clk);
        chk("done held d0", done[0], 1);
        chk("a_o zero in done d0", a_o[0], 0);
        chk("never started d4", done[4], 0);

        mode[2] = M_EXACT;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        chk("rerun busy d2", busy[2], 1);
        chk("rerun done d2", done[2], 0);
        chk("rerun samples clear d2", samples[2], 0);
        chk("rerun err_cnt clear d2", err_cnt[2], 0);
        chk("rerun sum_ae clear d2", sum_ae[2], 0);
        chk("rerun sum_se clear d2", sum_se[2], 0);
        chk("rerun wce clear d2", wce[2], 0);
        chk("rerun wce_a clear d2", wce_a[2], 0);
        chk("rerun wce_b clear d2", wce_b[2], 0);
        @(negedge clk);
        chk("rerun a_o idx1 d2", a_o[2], 1);
        chk("other dut unaffected d0", done[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
